cpu_sequencer: RTL and testbench
================================

# cpu_sequencer

Multi-cycle control sequencer for the 16-bit CPU. It owns the program counter and steps each instruction through fetch, execute, optional data-memory access and register writeback. It drives the instruction-memory dual-port addresses and all write/load strobes that the decoder currently ties off. It sits between the instruction/data memories, the decoder's classification flags and the register file/ALU enables.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  synchronous, active-high; overrides every other input
- start  input  1  leave IDLE/HALT and begin fetching; ignored in any other state
- hold  input  1  global stall; freezes state, PC and retired counter
- is_two_word  input  1  decoded instruction occupies pc and pc+1
- is_jump  input  1  decoded instruction is a branch/jump
- jump_taken  input  1  branch condition true; qualified by is_jump
- jump_target  input  16  branch destination
- is_load / is_store  input  1 each  data-memory access type; mutually exclusive
- is_halt  input  1  decoded instruction is HALT
- pc  output  16  current program counter
- instr_addr1 / instr_addr2  output  16  pc and pc+1 (modulo 2^16), combinational from pc
- ir_load  output  1  capture instruction words into IR
- exec_en  output  1  ALU/decoder execute strobe
- data_en  output  1  data-memory access cycle
- data_wen  output  1  data-memory write strobe
- reg_wen  output  1  register-file writeback strobe
- halted  output  1  FSM in HALT
- state  output  3  current state encoding, for debug
- retired  output  16  count of executed instructions

## Operation
- States: IDLE=0, FETCH=1, EXEC=2, MEM=3, WB=4, HALT=5. Encodings 6 and 7 are illegal and go to IDLE on the next edge.
- IDLE: all strobes 0. start -> FETCH.
- FETCH: instruction addresses are presented. The memory is synchronous, so the data is valid in the next cycle. -> EXEC.
- EXEC: ir_load=1, exec_en=1, retired+=1. The decoder flags are sampled this cycle. Next PC priority:
  - is_halt: pc+1, -> HALT
  - is_jump & jump_taken: jump_target
  - otherwise: pc+2 if is_two_word, else pc+1
- EXEC next state: is_load|is_store -> MEM, otherwise -> FETCH.
- MEM: data_en=1. data_wen=1 only if store (exactly one cycle). Load -> WB; store -> FETCH. The load/store type is latched in EXEC, so flag changes during MEM are ignored.
- WB: reg_wen=1, -> FETCH.
- HALT: halted=1, PC frozen. start -> FETCH and resumes at the instruction after the HALT.
- hold=1: state, pc and retired are unchanged. ir_load, exec_en, data_wen and reg_wen are forced to 0. data_en stays asserted in MEM. hold is ignored in IDLE and HALT.
- Arithmetic: PC and retired are 16-bit and wrap modulo 2^16 (0xFFFF+2 = 0x0001; retired 0xFFFF -> 0x0000).
- A jump on a two-word instruction uses jump_target; length is ignored.

## Timing
- Reset values: state=IDLE, pc=RESET_PC, retired=0. All strobes 0, halted=0. instr_addr1=RESET_PC, instr_addr2=RESET_PC+1.
- Reset mid-instruction (including during MEM with data_wen high): strobes drop in the reset cycle's successor. No partial writeback follows.
- Latency per instruction, no hold: ALU/jump 2 cycles (FETCH, EXEC); store 3; load 4.
- pc updates on the edge leaving EXEC. A MEM or WB phase sees the already-advanced pc.
- All strobes are registered-state decodes (Moore) except hold masking, which is combinational.
- start coincident with reset: reset wins, and start must be re-asserted.

## Structure
- Shared package cpu_pkg holds:
  - state encoding localparams (IDLE..HALT)
  - WORD_W=16
- Sub-module pc_next: combinational next-PC selector.
  - Inputs: pc, is_halt, is_jump, jump_taken, jump_target, is_two_word.
  - Output: 16-bit next pc.
  - Instantiated once.
- FSM, PC register, latched access type and retired counter live in cpu_sequencer.

## Test plan
- Reset, then start with one-word ALU at 0x0000: FETCH,EXEC in cycles 1-2. Then pc=0x0001, retired=1, exec_en high exactly one cycle.
- Two-word ALU at pc=0xFFFF: pc becomes 0x0001 and instr_addr2=0x0000 during FETCH.
- Store at pc=0x0010: data_wen high exactly one cycle (MEM), no reg_wen, next FETCH at pc=0x0011. Load: reg_wen one cycle after MEM, 4 cycles total.
- Taken two-word jump at 0x0020 to 0x0100: next FETCH pc=0x0100. Not taken: pc=0x0022.
- HALT at 0x0005: halted=1 and pc=0x0006 hold for 10 cycles. start then resumes FETCH at 0x0006.
- hold asserted 3 cycles during EXEC of a load: no strobes and retired unchanged during hold. On release, exec_en fires once and retired increments once. Assert reset during MEM of a store: data_wen is 0 the next cycle and state=IDLE, pc=RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU control path: datapath width,
// reset PC and the sequencer state encoding.
package cpu_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        MEM   = 3'd3,
        WB    = 3'd4,
        HALT  = 3'd5
    } state_t;

    localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 16'h0000;

endpackage

// File: rtl/cpu_sequencer_pc_next.sv
// Combinational next-PC selector used on the edge that leaves EXEC.
// HALT resumes at the following word; a taken jump ignores instruction length.
module pc_next
    import cpu_pkg::*;
(
    input  logic [WORD_W-1:0] pc,
    input  logic              is_halt,
    input  logic              is_jump,
    input  logic              jump_taken,
    input  logic [WORD_W-1:0] jump_target,
    input  logic              is_two_word,
    output logic [WORD_W-1:0] next_pc
);

    always_comb begin
        if (is_halt) begin
            next_pc = pc + WORD_W'(1);
        end else if (is_jump && jump_taken) begin
            next_pc = jump_target;
        end else if (is_two_word) begin
            next_pc = pc + WORD_W'(2);
        end else begin
            next_pc = pc + WORD_W'(1);
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: owns the PC and retired counter and steps
// each instruction through FETCH, EXEC, optional MEM and WB.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              hold,
    input  logic              is_two_word,
    input  logic              is_jump,
    input  logic              jump_taken,
    input  logic [WORD_W-1:0] jump_target,
    input  logic              is_load,
    input  logic              is_store,
    input  logic              is_halt,
    output logic [WORD_W-1:0] pc,
    output logic [WORD_W-1:0] instr_addr1,
    output logic [WORD_W-1:0] instr_addr2,
    output logic              ir_load,
    output logic              exec_en,
    output logic              data_en,
    output logic              data_wen,
    output logic              reg_wen,
    output logic              halted,
    output logic [2:0]        state,
    output logic [WORD_W-1:0] retired
);

    state_t            state_q, state_d;
    logic [WORD_W-1:0] pc_q, retired_q, pc_nxt;
    logic              store_q;
    logic              retire;

    pc_next u_pc_next (
        .pc          (pc_q),
        .is_halt     (is_halt),
        .is_jump     (is_jump),
        .jump_taken  (jump_taken),
        .jump_target (jump_target),
        .is_two_word (is_two_word),
        .next_pc     (pc_nxt)
    );

    // An instruction retires on the single unheld EXEC cycle.
    assign retire = (state_q == EXEC) && !hold;

    // NOTE: registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            retired_q <= '0;
            store_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                pc_q      <= pc_nxt;
                retired_q <= retired_q + WORD_W'(1);
                store_q   <= is_store;
            end
        end
    end

    // NOTE: every output of this block is given a default first so no path
    // leaves a signal unassigned and infers a latch.
    always_comb begin
        state_d  = state_q;
        ir_load  = 1'b0;
        exec_en  = 1'b0;
        data_en  = 1'b0;
        data_wen = 1'b0;
        reg_wen  = 1'b0;
        halted   = 1'b0;
        unique case (state_q)
            IDLE: if (start) state_d = FETCH;
            FETCH: if (!hold) state_d = EXEC;
            EXEC: begin
                ir_load = !hold;
                exec_en = !hold;
                if (!hold) begin
                    if (is_halt)                  state_d = HALT;
                    else if (is_load || is_store) state_d = MEM;
                    else                          state_d = FETCH;
                end
            end
            MEM: begin
                // data_en stays up through a stall; only the write is masked.
                data_en  = 1'b1;
                data_wen = store_q && !hold;
                if (!hold) state_d = store_q ? FETCH : WB;
            end
            WB: begin
                reg_wen = !hold;
                if (!hold) state_d = FETCH;
            end
            HALT: begin
                halted = 1'b1;
                if (start) state_d = FETCH;
            end
            default: state_d = IDLE;
        endcase
    end

    assign pc          = pc_q;
    assign instr_addr1 = pc_q;
    assign instr_addr2 = pc_q + WORD_W'(1);
    assign retired     = retired_q;
    assign state       = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed scenarios plus randomized
// instruction streams checked cycle by cycle against a per-instruction model.
module tb_cpu_sequencer;

    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_EXEC = 3'd2,
                           S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd5;
    // strobe vector order: {ir_load, exec_en, data_en, data_wen, reg_wen, halted}
    localparam logic [5:0] ST_NONE = 6'b000000, ST_EXEC = 6'b110000,
                           ST_MEMW = 6'b001100, ST_MEMR = 6'b001000,
                           ST_WB = 6'b000010, ST_HALT = 6'b000001;

    typedef struct packed {
        logic        two;
        logic        jmp;
        logic        taken;
        logic [15:0] tgt;
        logic        ld;
        logic        st;
        logic        hlt;
    } flags_t;

    logic clk = 1'b0;
    logic reset, start, hold;
    logic is_two_word, is_jump, jump_taken, is_load, is_store, is_halt;
    logic [15:0] jump_target;
    logic [15:0] pc, instr_addr1, instr_addr2, retired;
    logic ir_load, exec_en, data_en, data_wen, reg_wen, halted;
    logic [2:0] state;

    int total = 0;
    int bad = 0;
    logic [15:0] m_pc;
    logic [15:0] m_ret;

    always #5 clk = ~clk;

    cpu_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .hold        (hold),
        .is_two_word (is_two_word),
        .is_jump     (is_jump),
        .jump_taken  (jump_taken),
        .jump_target (jump_target),
        .is_load     (is_load),
        .is_store    (is_store),
        .is_halt     (is_halt),
        .pc          (pc),
        .instr_addr1 (instr_addr1),
        .instr_addr2 (instr_addr2),
        .ir_load     (ir_load),
        .exec_en     (exec_en),
        .data_en     (data_en),
        .data_wen    (data_wen),
        .reg_wen     (reg_wen),
        .halted      (halted),
        .state       (state),
        .retired     (retired)
    );

    function automatic logic [72:0] snap();
        return {state, pc, retired, ir_load, exec_en, data_en, data_wen, reg_wen, halted,
                instr_addr1, instr_addr2};
    endfunction

    function automatic logic [72:0] mk(logic [2:0] st, logic [15:0] p, logic [15:0] r,
                                       logic [5:0] strb);
        logic [15:0] p1;
        p1 = p + 16'd1;
        return {st, p, r, strb, p, p1};
    endfunction

    function automatic flags_t fl(logic two, logic jmp, logic taken, logic [15:0] tgt,
                                  logic ld, logic st, logic hlt);
        flags_t f;
        f.two = two; f.jmp = jmp; f.taken = taken; f.tgt = tgt;
        f.ld = ld; f.st = st; f.hlt = hlt;
        return f;
    endfunction

    // Architectural next PC from the instruction's own flags.
    function automatic logic [15:0] model_next(logic [15:0] p, flags_t f);
        if (f.hlt) return p + 16'd1;
        if (f.jmp && f.taken) return f.tgt;
        return f.two ? p + 16'd2 : p + 16'd1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_flags(flags_t f);
        is_two_word = f.two; is_jump = f.jmp; jump_taken = f.taken;
        jump_target = f.tgt; is_load = f.ld; is_store = f.st; is_halt = f.hlt;
    endtask

    // Flags outside EXEC carry no meaning; scramble them to prove they are ignored.
    task automatic drive_junk();
        logic [6:0] r;
        r = 7'($urandom);
        is_two_word = r[0]; is_jump = r[1]; jump_taken = r[2];
        is_load = r[3]; is_store = r[4] & ~r[3]; is_halt = r[5];
        jump_target = 16'($urandom);
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; hold = 1'b0;
        drive_junk();
        step();
        reset = 1'b0;
        m_pc = 16'h0000;
        m_ret = 16'h0000;
    endtask

    task automatic kick(string name);
        start = 1'b1;
        #1;
        total++;
        if (snap() !== mk(S_IDLE, m_pc, m_ret, ST_NONE)) begin
            bad++;
            $display("FAIL %s idle: got %h exp %h", name, snap(), mk(S_IDLE, m_pc, m_ret, ST_NONE));
        end
        step();
        start = 1'b0;
    endtask

    // Runs one instruction starting in FETCH; hf/he/hm/hw are hold cycles per phase.
    task automatic run_instr(string name, flags_t f, int hf, int he, int hm, int hw,
                             bit reset_in_mem);
        logic [72:0] e;
        for (int i = 0; i <= hf; i++) begin
            hold = (i < hf);
            drive_junk();
            #1;
            e = mk(S_FETCH, m_pc, m_ret, ST_NONE);
            total++;
            if (snap() !== e) begin
                bad++;
                $display("FAIL %s fetch: got %h exp %h", name, snap(), e);
            end
            step();
        end
        drive_flags(f);
        for (int i = 0; i <= he; i++) begin
            hold = (i < he);
            #1;
            e = mk(S_EXEC, m_pc, m_ret, (i < he) ? ST_NONE : ST_EXEC);
            total++;
            if (snap() !== e) begin
                bad++;
                $display("FAIL %s exec: got %h exp %h", name, snap(), e);
            end
            step();
        end
        m_ret = m_ret + 16'd1;
        m_pc = model_next(m_pc, f);
        hold = 1'b0;
        if (f.hlt || !(f.ld || f.st)) return;
        for (int i = 0; i <= hm; i++) begin
            hold = (i < hm);
            drive_junk();
            #1;
            e = mk(S_MEM, m_pc, m_ret, (f.st && i == hm) ? ST_MEMW : ST_MEMR);
            total++;
            if (snap() !== e) begin
                bad++;
                $display("FAIL %s mem: got %h exp %h", name, snap(), e);
            end
            if (reset_in_mem && i == hm) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
                hold = 1'b0;
                m_pc = 16'h0000;
                m_ret = 16'h0000;
                #1;
                e = mk(S_IDLE, m_pc, m_ret, ST_NONE);
                total++;
                if (snap() !== e) begin
                    bad++;
                    $display("FAIL %s reset_in_mem: got %h exp %h", name, snap(), e);
                end
                return;
            end
            step();
        end
        if (f.ld) begin
            for (int i = 0; i <= hw; i++) begin
                hold = (i < hw);
                drive_junk();
                #1;
                e = mk(S_WB, m_pc, m_ret, (i < hw) ? ST_NONE : ST_WB);
                total++;
                if (snap() !== e) begin
                    bad++;
                    $display("FAIL %s wb: got %h exp %h", name, snap(), e);
                end
                step();
            end
        end
        hold = 1'b0;
    endtask

    // Sits in HALT for n cycles with noise on hold and flags, then restarts.
    task automatic halt_wait(string name, int n);
        logic [72:0] e;
        for (int i = 0; i <= n; i++) begin
            hold = 1'($urandom);
            start = (i == n);
            drive_junk();
            #1;
            e = mk(S_HALT, m_pc, m_ret, ST_HALT);
            total++;
            if (snap() !== e) begin
                bad++;
                $display("FAIL %s halt cycle %0d: got %h exp %h", name, i, snap(), e);
            end
            step();
        end
        start = 1'b0;
        hold = 1'b0;
    endtask

    task automatic goto_pc(logic [15:0] tgt);
        run_instr("goto", fl(1'b0, 1'b1, 1'b1, tgt, 1'b0, 1'b0, 1'b0), 0, 0, 0, 0, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; hold = 1'b0;
        drive_junk();
        step();
        step();
        m_pc = 16'h0000;
        m_ret = 16'h0000;
        reset = 1'b0; start = 1'b0;
        #1;
        total++;
        if (snap() !== mk(S_IDLE, 16'h0000, 16'h0000, ST_NONE)) begin
            bad++;
            $display("FAIL reset_state: got %h exp %h", snap(), mk(S_IDLE, 16'h0000, 16'h0000, ST_NONE));
        end
        step();
        total++;
        if (state !== S_IDLE) begin
            bad++;
            $display("FAIL reset_start_ignored: got state %0d exp %0d", state, S_IDLE);
        end
    endtask

    task automatic test_alu();
        kick("alu");
        run_instr("alu1", fl(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0), 0, 0, 0, 0, 1'b0);
        #1;
        total++;
        if (pc !== 16'h0001 || retired !== 16'h0001 || exec_en !== 1'b0) begin
            bad++;
            $display("FAIL alu_after: got pc=%h ret=%h exec_en=%b exp 0001 0001 0", pc, retired, exec_en);
        end
    endtask

    task automatic test_wrap();
        goto_pc(16'hFFFF);
        run_instr("two_word_wrap", fl(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0), 0, 0, 0, 0, 1'b0);
        total++;
        if (pc !== 16'h0001) begin
            bad++;
            $display("FAIL wrap_pc: got %h exp 0001", pc);
        end
    endtask

    task automatic test_store_load();
        goto_pc(16'h0010);
        run_instr("store", fl(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0), 0, 0, 0, 0, 1'b0);
        run_instr("load", fl(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0), 0, 0, 0, 0, 1'b0);
        total++;
        if (pc !== 16'h0012) begin
            bad++;
            $display("FAIL store_load_pc: got %h exp 0012", pc);
        end
    endtask

    task automatic test_jump();
        goto_pc(16'h0020);
        run_instr("jump_taken", fl(1'b1, 1'b1, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b0), 0, 0, 0, 0, 1'b0);
        goto_pc(16'h0020);
        run_instr("jump_not_taken", fl(1'b1, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0), 0, 0, 0, 0, 1'b0);
        run_instr("after_not_taken", fl(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0), 0, 0, 0, 0, 1'b0);
    endtask

    task automatic test_halt();
        goto_pc(16'h0005);
        run_instr("halt", fl(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1), 0, 0, 0, 0, 1'b0);
        halt_wait("halt", 10);
        run_instr("resume", fl(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0), 0, 0, 0, 0, 1'b0);
    endtask

    task automatic test_hold();
        run_instr("hold_exec_load", fl(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0), 0, 3, 0, 0, 1'b0);
        run_instr("hold_all_store", fl(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0), 2, 1, 2, 0, 1'b0);
        run_instr("hold_all_load", fl(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0), 1, 1, 2, 2, 1'b0);
    endtask

    task automatic test_reset_mid();
        run_instr("reset_mid_store", fl(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0), 0, 0, 0, 0, 1'b1);
    endtask

    task automatic test_random(int n);
        flags_t f;
        int hf, he, hm, hw;
        kick("random");
        for (int k = 0; k < n; k++) begin
            f.two = 1'($urandom);
            f.jmp = ($urandom_range(0, 3) == 0);
            f.taken = 1'($urandom);
            f.tgt = 16'($urandom);
            f.hlt = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 2))
                0: begin f.ld = 1'b1; f.st = 1'b0; end
                1: begin f.ld = 1'b0; f.st = 1'b1; end
                default: begin f.ld = 1'b0; f.st = 1'b0; end
            endcase
            if (f.hlt) begin f.ld = 1'b0; f.st = 1'b0; end
            hf = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
            he = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
            hm = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
            hw = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
            run_instr("random", f, hf, he, hm, hw, 1'b0);
            if (f.hlt) halt_wait("random_halt", $urandom_range(1, 4));
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; hold = 1'b0;
        drive_junk();
        test_reset();
        test_alu();
        test_wrap();
        test_store_load();
        test_jump();
        test_halt();
        test_hold();
        test_reset_mid();
        test_random(150);
        do_reset();
        test_random(60);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
